shared_timer_arbiter: RTL and testbench
=======================================

Name: shared_timer_arbiter

Overview:
- Round-robin controller that shares one down-counting timer datapath between NUM_REQ requesters.
- Each requester asserts req with a load value. The block grants the timer to one requester, counts the value down to zero and pulses done back to that requester.
- Sits between parameterized counter users in test designs and a single counter resource.
- All widths are overridable per instance by #() or defparam.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- WIDTH, 8, timer/load value width in bits.
- IDX_W, 2, owner index width; instantiator sets it to ceil(log2(NUM_REQ)).

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req  input  NUM_REQ  per-requester request level; held until done or abandoned.
- req_cnt  input  NUM_REQ*WIDTH  flattened load values; slice i is bits [i*WIDTH +: WIDTH].
- gnt  output  NUM_REQ  one-hot grant, registered.
- done  output  NUM_REQ  one-hot single-cycle completion pulse, registered.
- busy  output  1  high while in RUN.
- owner  output  IDX_W  index of current/last grantee.
- count  output  WIDTH  live timer value.

Behaviour:
- Reset (rst_n low, async): state=IDLE; gnt, done, busy, owner, count = 0; round-robin pointer ptr = 0. Outputs go to 0 without waiting for a clock edge.
- States are IDLE, RUN, DONE; 2-bit encoding.
- IDLE edge, any req set:
  - Winner = first set req[i] scanning ptr, ptr+1, ... mod NUM_REQ.
  - Next state RUN; gnt <= onehot(i), owner <= i, count <= req_cnt slice i, busy <= 1.
  - No req set: stay in IDLE, outputs unchanged except done = 0.
- RUN edge, in priority order:
  - (a) req[owner] == 0 (abort): state <= IDLE, gnt <= 0, busy <= 0, no done, ptr <= owner+1 mod NUM_REQ, count holds.
  - (b) count == 0: state <= DONE, gnt <= 0, busy <= 0, done <= onehot(owner).
  - (c) otherwise: count <= count - 1.
- DONE edge: done <= 0, ptr <= owner+1 mod NUM_REQ, state <= IDLE. req is ignored in DONE.
- Timing: load value L gives gnt high for exactly L+1 cycles and done high for exactly 1 cycle, starting on the edge where gnt falls.
- Back-to-back service: IDLE always lasts at least 1 cycle, so each grant occupies L+3 cycles total.
- L = 0: gnt high for 1 cycle, then done.
- Requests arriving during RUN/DONE are not considered until the next IDLE edge. Changes to req_cnt during RUN are ignored (value was latched at grant).
- Wrap-around: ptr wraps from NUM_REQ-1 to 0. count never decrements below 0.
- gnt and done are never both nonzero in the same cycle, and each has at most one bit set.
- count in IDLE holds the last value (0 after normal completion).

Decomposition:
- Shared include shared_timer_defs.vh: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
- One sub-module, rr_pick: combinational.
  - Inputs: req, ptr.
  - Outputs: valid, idx.
  - Same NUM_REQ/IDX_W parameters, passed through.
- The top block holds the FSM, timer register and ptr.

Test Plan:
All cases use defaults NUM_REQ=4, WIDTH=8 unless stated.
1. Reset: hold rst_n=0 for 3 cycles with req=4'b1111 -> gnt=0, done=0, busy=0, count=0. Assert rst_n=0 asynchronously mid-cycle -> outputs clear before the next edge.
2. Single request: req=4'b0010, slice1=3 -> gnt=4'b0010 from the next edge for 4 cycles, count 3,2,1,0, then done=4'b0010 for 1 cycle, owner=1. Drop req on done.
3. Fairness: req=4'b1111, all slices=1, each requester re-requests after its done -> grant order 0,1,2,3,0. Each grant spans 4 cycles (L+3).
4. Zero load: req[3]=1, slice3=0 -> gnt=4'b1000 for 1 cycle, then done=4'b1000. Next simultaneous req 4'b1001 -> grant to 0 (ptr wrapped).
5. Abort and mid-run reset:
   - req[2] with slice2=9; drop req[2] when count=5 -> gnt=0 next edge, no done pulse; pending req[3] granted next.
   - Repeat the run and pulse rst_n low at count=4 -> immediate clear, ptr=0, so req=4'b1001 then grants 0.
6. Parameter override: instance with defparam u.NUM_REQ=2, u.WIDTH=16, u.IDX_W=1; slice0=16'd300 -> gnt held 301 cycles, count wraps to 0 without underflow, done=2'b01.

Source files
------------

// File: rtl/shared_timer_arbiter_pkg.sv
// Shared types and defaults for the round-robin timer arbiter.
// State encodings are fixed so external debug tooling can decode them.
package shared_timer_arbiter_pkg;

  localparam int unsigned STATE_W     = 2;
  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_IDX_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping from NUM_REQ-1 back to 0.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/shared_timer_arbiter.sv
// Shares one down-counting timer between NUM_REQ requesters, granting
// round-robin and pulsing done to the owner when its load value expires.
module shared_timer_arbiter
  import shared_timer_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned IDX_W   = DEF_IDX_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_cnt,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [IDX_W-1:0]         owner,
  output logic [WIDTH-1:0]         count
);

  state_e               state_q;
  state_e               state_d;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [NUM_REQ-1:0]   gnt_d;
  logic [NUM_REQ-1:0]   done_q;
  logic [NUM_REQ-1:0]   done_d;
  logic                 busy_q;
  logic                 busy_d;
  logic [IDX_W-1:0]     owner_q;
  logic [IDX_W-1:0]     owner_d;
  logic [WIDTH-1:0]     count_q;
  logic [WIDTH-1:0]     count_d;
  logic [IDX_W-1:0]     ptr_q;
  logic [IDX_W-1:0]     ptr_d;

  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     ptr_after_owner;
  logic                 owner_req;
  logic                 count_zero;
  logic [WIDTH-1:0]     load_val [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_load
    assign load_val[g] = req_cnt[g*WIDTH +: WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Next fairness pointer: the requester just after the current owner.
  assign ptr_after_owner = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0
                                                            : owner_q + IDX_W'(1);
  assign owner_req       = req[owner_q];
  assign count_zero      = (count_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
      count_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (pick_valid) state_d = ST_RUN;
      ST_RUN: begin
        if (!owner_req)     state_d = ST_IDLE;
        else if (count_zero) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Abort (owner dropped req) outranks completion so no done is issued.
  always_comb begin
    gnt_d   = gnt_q;
    done_d  = '0;
    busy_d  = busy_q;
    owner_d = owner_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_d   = NUM_REQ'(1) << pick_idx;
          owner_d = pick_idx;
          count_d = load_val[pick_idx];
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (!owner_req) begin
          gnt_d  = '0;
          busy_d = 1'b0;
          ptr_d  = ptr_after_owner;
        end else if (count_zero) begin
          gnt_d  = '0;
          busy_d = 1'b0;
          done_d = NUM_REQ'(1) << owner_q;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      ST_DONE: begin
        ptr_d = ptr_after_owner;
      end
      default: begin
        gnt_d  = '0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign owner = owner_q;
  assign count = count_q;

endmodule

// File: tb/tb_shared_timer_arbiter.sv
// Scoreboard bench: a timestamp-based service model predicts every cycle's
// outputs; a negedge monitor pops and compares, plus directed event checks.
module tb_shared_timer_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   req_cnt = '0;
  logic [N-1:0]     gnt;
  logic [N-1:0]     done;
  logic             busy;
  logic [1:0]       owner;
  logic [W-1:0]     count;

  logic [1:0]       req_w = '0;
  logic [31:0]      req_cnt_w = '0;
  logic [1:0]       gnt_w;
  logic [1:0]       done_w;
  logic             busy_w;
  logic [0:0]       owner_w;
  logic [15:0]      count_w;

  always #5 clk = ~clk;

  shared_timer_arbiter #(.NUM_REQ(4), .WIDTH(8), .IDX_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_cnt(req_cnt),
    .gnt(gnt), .done(done), .busy(busy), .owner(owner), .count(count)
  );

  shared_timer_arbiter #(.NUM_REQ(2), .WIDTH(16), .IDX_W(1)) u_wide (
    .clk(clk), .rst_n(rst_n), .req(req_w), .req_cnt(req_cnt_w),
    .gnt(gnt_w), .done(done_w), .busy(busy_w), .owner(owner_w), .count(count_w)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [N-1:0] gnt;
    logic [N-1:0] done;
    logic         busy;
    logic [1:0]   owner;
    logic [W-1:0] count;
  } snap_t;

  snap_t      exp_q[$];
  snap_t      m_e;
  int         m_ptr, m_owner, m_L, m_t0, m_cyc, m_rem, m_j;
  bit         m_svc, m_fin, m_found;
  logic [W-1:0] m_cnt;

  // A service granted at cycle t0 with load L shows count L-(c-t0) until it
  // reaches 0; the done cycle follows, then one idle cycle before the next grant.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr = 0; m_owner = 0; m_L = 0; m_t0 = 0; m_cyc = 0;
      m_svc = 0; m_fin = 0; m_cnt = '0;
      exp_q.delete();
    end else begin
      m_cyc++;
      m_e.done = '0;
      if (m_fin) begin
        m_fin = 0;
        m_ptr = (m_owner + 1) % N;
      end else if (m_svc) begin
        m_rem = m_L - (m_cyc - 1 - m_t0);
        if (!req[m_owner]) begin
          m_svc = 0;
          m_cnt = W'(m_rem);
          m_ptr = (m_owner + 1) % N;
        end else if (m_rem == 0) begin
          m_svc = 0;
          m_fin = 1;
          m_cnt = '0;
          m_e.done = N'(1) << m_owner;
        end
      end else begin
        m_found = 0;
        for (int k = 0; k < N; k++) begin
          m_j = (m_ptr + k) % N;
          if (!m_found && req[m_j]) begin
            m_found = 1;
            m_svc = 1;
            m_owner = m_j;
            m_L = int'(req_cnt[m_j*W +: W]);
            m_t0 = m_cyc;
          end
        end
      end
      m_e.gnt   = m_svc ? (N'(1) << m_owner) : '0;
      m_e.busy  = m_svc;
      m_e.owner = 2'(m_owner);
      m_e.count = m_svc ? W'(m_L - (m_cyc - m_t0)) : m_cnt;
      exp_q.push_back(m_e);
    end
  end

  // ---------------- monitor ----------------
  int         gnt_log[$];
  int         gnt_start[$];
  int         len_log[$];
  logic [N-1:0] done_acc = '0;
  logic [N-1:0] prev_gnt = '0;
  int         run_len = 0;
  int         ncyc = 0;
  snap_t      s;

  always @(negedge clk) begin
    ncyc++;
    if (rst_n) begin
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        chk("gnt", 32'(gnt), 32'(s.gnt));
        chk("done", 32'(done), 32'(s.done));
        chk("busy", 32'(busy), 32'(s.busy));
        chk("owner", 32'(owner), 32'(s.owner));
        chk("count", 32'(count), 32'(s.count));
      end
      done_acc = done_acc | done;
      if (gnt != 0 && prev_gnt == 0) begin
        gnt_log.push_back(int'(owner));
        gnt_start.push_back(ncyc);
        run_len = 0;
      end
      if (gnt != 0) run_len++;
      if (gnt == 0 && prev_gnt != 0) len_log.push_back(run_len);
      prev_gnt = gnt;
    end else begin
      prev_gnt = '0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_slice(input int i, input int v);
    req_cnt[i*W +: W] = W'(v);
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    gnt_start.delete();
    len_log.delete();
    done_acc = '0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int t;
    t = 0;
    while (!done[i] && t < budget) begin
      step(1);
      t++;
    end
    chk($sformatf("wait_done%0d", i), 32'(done[i]), 32'd1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, n, idx;

    // 1. reset held with all requests asserted
    req = 4'b1111;
    for (int i = 0; i < N; i++) set_slice(i, 5);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_count", 32'(count), 0);
    end
    req = '0;
    #1 rst_n = 1'b1;

    // 2. single request, L=3
    step(1);
    clear_logs();
    req = 4'b0010;
    set_slice(1, 3);
    wait_done(1, 20);
    req = '0;
    chk("single_owner", 32'(owner), 1);
    step(1);
    chk("single_len", 32'(len_log.size() > 0 ? len_log[0] : -1), 4);
    chk("single_who", 32'(gnt_log.size() > 0 ? gnt_log[0] : -1), 1);

    // 3. fairness from a fresh pointer
    rst_n = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < N; i++) set_slice(i, 1);
    @(negedge clk);
    @(negedge clk);
    clear_logs();
    #1 rst_n = 1'b1;
    step(1);
    t = 0;
    while (gnt_log.size() < 5 && t < 100) begin step(1); t++; end
    wait_done(0, 20);
    req = '0;
    step(1);
    chk("fair_cnt", 32'(gnt_log.size()), 5);
    for (int i = 0; i < 5 && i < gnt_log.size(); i++)
      chk($sformatf("fair_order%0d", i), 32'(gnt_log[i]), 32'(i % N));
    for (int i = 0; i < 4 && i + 1 < gnt_start.size(); i++)
      chk($sformatf("fair_spacing%0d", i), 32'(gnt_start[i+1] - gnt_start[i]), 4);
    for (int i = 0; i < 2 && i < len_log.size(); i++)
      chk($sformatf("fair_len%0d", i), 32'(len_log[i]), 2);

    // 4. zero load, then pointer wrap to 0
    step(2);
    clear_logs();
    req = 4'b1000;
    set_slice(3, 0);
    set_slice(0, 2);
    wait_done(3, 20);
    req = 4'b1001;
    wait_done(0, 20);
    req = '0;
    step(1);
    chk("zero_len", 32'(len_log.size() > 0 ? len_log[0] : -1), 1);
    chk("wrap_first", 32'(gnt_log.size() > 0 ? gnt_log[0] : -1), 3);
    chk("wrap_second", 32'(gnt_log.size() > 1 ? gnt_log[1] : -1), 0);

    // 5a. abort at count 5, pending requester served next
    step(2);
    clear_logs();
    req = 4'b1100;
    set_slice(2, 9);
    set_slice(3, 2);
    t = 0;
    while (!(gnt[2] && count == 8'd5) && t < 50) begin step(1); t++; end
    chk("abort_point", 32'(count), 5);
    req[2] = 1'b0;
    wait_done(3, 30);
    req = '0;
    step(1);
    chk("abort_len", 32'(len_log.size() > 0 ? len_log[0] : -1), 5);
    chk("abort_next", 32'(gnt_log.size() > 1 ? gnt_log[1] : -1), 3);
    chk("abort_no_done", 32'(done_acc), 32'(4'b1000));

    // 5b. asynchronous reset in mid-run
    step(2);
    req = 4'b0100;
    set_slice(2, 9);
    t = 0;
    while (!(gnt[2] && count == 8'd4) && t < 50) begin step(1); t++; end
    chk("rst_point", 32'(count), 4);
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_owner", 32'(owner), 0);
    req = 4'b1001;
    set_slice(0, 1);
    set_slice(3, 1);
    @(negedge clk);
    clear_logs();
    #1 rst_n = 1'b1;
    step(1);
    wait_done(0, 20);
    req = '0;
    chk("arst_regrant", 32'(gnt_log.size() > 0 ? gnt_log[0] : -1), 0);

    // randomized traffic, checked cycle-by-cycle by the scoreboard
    step(2);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (done[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
        else if (req[i] && gnt[i] && $urandom_range(0, 29) == 0) req[i] = 1'b0;
        else if (req[i] && !gnt[i] && $urandom_range(0, 49) == 0) req[i] = 1'b0;
      end
      if ($urandom_range(0, 1) == 1) begin
        idx = int'($urandom_range(0, N - 1));
        set_slice(idx, int'($urandom_range(0, 6)));
      end
      step(1);
    end
    req = '0;
    step(20);

    // 6. wide instance: 16-bit load of 300
    req_w = 2'b01;
    req_cnt_w[15:0] = 16'd300;
    t = 0;
    while (gnt_w == 2'b00 && t < 5) begin step(1); t++; end
    chk("wide_load", 32'(count_w), 300);
    chk("wide_owner", 32'(owner_w), 0);
    n = 1;
    t = 0;
    while (t < 400) begin
      step(1);
      t++;
      if (gnt_w == 2'b01) n++;
      else break;
    end
    chk("wide_len", 32'(n), 301);
    chk("wide_done", 32'(done_w), 32'(2'b01));
    chk("wide_count", 32'(count_w), 0);
    chk("wide_busy", 32'(busy_w), 0);
    req_w = 2'b00;
    step(1);
    chk("wide_done_pulse", 32'(done_w), 0);

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
